// File: rtl/io_pkg.sv
// io_pkg: shared IO-bus word addresses and board input widths for the
// memory-mapped input and output ports.
`default_nettype none
`timescale 1ns/1ps

package io_pkg;

  localparam int SW_W  = 10;
  localparam int KEY_W = 4;

  localparam logic [4:0] IO_SW_LO   = 5'd5;
  localparam logic [4:0] IO_SW_HI   = 5'd6;
  localparam logic [4:0] IO_SW_ALL  = 5'd7;
  localparam logic [4:0] IO_KEY_LVL = 5'd10;
  localparam logic [4:0] IO_KEY_EVT = 5'd11;
  localparam logic [4:0] IO_SW_CHG  = 5'd12;
  localparam logic [4:0] IO_IRQ_CFG = 5'd13;

endpackage

`default_nettype wire

// File: rtl/debounce_cell.sv
// debounce_cell: one input bit -> 2-FF synchroniser -> counter debounce.
// Emits the stable level plus a single-cycle rise/fall pulse on the update edge.
`default_nettype none
`timescale 1ns/1ps

module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic resetn,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    flip     = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        flip     = 1'b1;
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // Pulses coincide with the edge that updates stable, so event flags land with it.
  assign stable = stable_q;
  assign rise   = flip & sync2_q;
  assign fall   = flip & ~sync2_q;

endmodule

`default_nettype wire

// File: rtl/io_input_ctrl.sv
// io_input_ctrl: memory-mapped switch/key input port with debounce, sticky
// event flags (clear-on-read and W1C), a mask register and a registered irq.
`default_nettype none
`timescale 1ns/1ps

module io_input_ctrl
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [4:0]        addr,
  input  logic              read_enable,
  input  logic              write_enable,
  input  logic [31:0]       data_in,
  input  logic [SW_W-1:0]   io_in_sw,
  input  logic [KEY_W-1:0]  io_in_key,
  output logic [31:0]       data_out,
  output logic              irq
);

  logic [SW_W-1:0]  sw_stable, sw_rise, sw_fall;
  logic [KEY_W-1:0] key_stable, key_rise, key_fall;
  logic [KEY_W-1:0] key_pressed;

  logic [KEY_W-1:0] key_evt_q, key_evt_d;
  logic [SW_W-1:0]  sw_chg_q, sw_chg_d;
  logic [KEY_W-1:0] key_mask_q, key_mask_d;
  logic             sw_irq_en_q, sw_irq_en_d;
  logic [31:0]      data_out_q, data_out_d;
  logic             irq_q, irq_d;
  logic [31:0]      rd_data;
  logic             unused_bits;

  assign key_pressed = ~io_in_key;

  generate
    for (genvar i = 0; i < SW_W; i++) begin : g_sw
      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
        .clock  (clock),
        .resetn (resetn),
        .din    (io_in_sw[i]),
        .stable (sw_stable[i]),
        .rise   (sw_rise[i]),
        .fall   (sw_fall[i])
      );
    end
    for (genvar i = 0; i < KEY_W; i++) begin : g_key
      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
        .clock  (clock),
        .resetn (resetn),
        .din    (key_pressed[i]),
        .stable (key_stable[i]),
        .rise   (key_rise[i]),
        .fall   (key_fall[i])
      );
    end
  endgenerate

  always_comb begin
    case (addr)
      IO_SW_LO:   rd_data = {27'b0, sw_stable[4:0]};
      IO_SW_HI:   rd_data = {27'b0, sw_stable[9:5]};
      IO_SW_ALL:  rd_data = {22'b0, sw_stable};
      IO_KEY_LVL: rd_data = {28'b0, key_stable};
      IO_KEY_EVT: rd_data = {28'b0, key_evt_q};
      IO_SW_CHG:  rd_data = {22'b0, sw_chg_q};
      IO_IRQ_CFG: rd_data = {27'b0, sw_irq_en_q, key_mask_q};
      default:    rd_data = 32'b0;
    endcase
  end

  // Clears apply first and new events are OR'd in last so a same-cycle event survives.
  always_comb begin
    key_evt_d   = key_evt_q;
    sw_chg_d    = sw_chg_q;
    key_mask_d  = key_mask_q;
    sw_irq_en_d = sw_irq_en_q;

    if (read_enable && addr == IO_KEY_EVT)  key_evt_d = '0;
    if (write_enable && addr == IO_KEY_EVT) key_evt_d = key_evt_d & ~data_in[KEY_W-1:0];
    key_evt_d = key_evt_d | key_rise;

    if (read_enable && addr == IO_SW_CHG)   sw_chg_d = '0;
    if (write_enable && addr == IO_SW_CHG)  sw_chg_d = sw_chg_d & ~data_in[SW_W-1:0];
    sw_chg_d = sw_chg_d | sw_rise | sw_fall;

    if (write_enable && addr == IO_IRQ_CFG) begin
      key_mask_d  = data_in[KEY_W-1:0];
      sw_irq_en_d = data_in[KEY_W];
    end

    data_out_d = read_enable ? rd_data : data_out_q;
    irq_d      = (|(key_evt_d & key_mask_d)) | ((|sw_chg_d) & sw_irq_en_d);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_evt_q   <= '0;
      sw_chg_q    <= '0;
      key_mask_q  <= '0;
      sw_irq_en_q <= 1'b0;
      data_out_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      key_evt_q   <= key_evt_d;
      sw_chg_q    <= sw_chg_d;
      key_mask_q  <= key_mask_d;
      sw_irq_en_q <= sw_irq_en_d;
      data_out_q  <= data_out_d;
      irq_q       <= irq_d;
    end
  end

  assign data_out = data_out_q;
  assign irq      = irq_q;

  assign unused_bits = ^{data_in[31:SW_W], key_fall};

endmodule

`default_nettype wire

// File: tb/tb_io_input_ctrl.sv
// tb_io_input_ctrl: directed stimulus with a read-data scoreboard for io_input_ctrl.
`default_nettype none
`timescale 1ns/1ps

module tb_io_input_ctrl;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [4:0]  addr = '0;
  logic        read_enable = 1'b0;
  logic        write_enable = 1'b0;
  logic [31:0] data_in = '0;
  logic [9:0]  io_in_sw = '0;
  logic [3:0]  io_in_key = 4'hF;
  logic [31:0] data_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_flag = 1'b0;

  io_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .addr         (addr),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .data_in      (data_in),
    .io_in_sw     (io_in_sw),
    .io_in_key    (io_in_key),
    .data_out     (data_out),
    .irq          (irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: data_out is valid on the negedge following a sampled read strobe.
  always @(posedge clock) rd_flag <= read_enable & resetn;

  always @(negedge clock) begin
    if (rd_flag) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got 0x%0h, expected no read", data_out);
      end else begin
        check(name_q.pop_front(), data_out, exp_q.pop_front());
      end
    end
  end

  // All stimulus tasks enter and leave on a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    addr        = a;
    read_enable = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clock);
    read_enable = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    addr         = a;
    data_in      = d;
    write_enable = 1'b1;
    @(negedge clock);
    write_enable = 1'b0;
    data_in      = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset
    tick(3);
    check("rst_data_out", data_out, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    resetn = 1'b1;
    tick(1);
    rd(5'd5,  32'h0, "rst_rd5");
    rd(5'd6,  32'h0, "rst_rd6");
    rd(5'd7,  32'h0, "rst_rd7");
    rd(5'd10, 32'h0, "rst_rd10");
    rd(5'd11, 32'h0, "rst_rd11");
    rd(5'd12, 32'h0, "rst_rd12");
    rd(5'd13, 32'h0, "rst_rd13");

    // 2. switches
    io_in_sw = 10'h2A5;
    tick(8);
    rd(5'd7,  32'h2A5, "sw_all");
    rd(5'd5,  32'h05,  "sw_lo");
    rd(5'd6,  32'h15,  "sw_hi");
    rd(5'd12, 32'h2A5, "sw_chg");
    rd(5'd12, 32'h0,   "sw_chg_cleared");

    // 3. short key glitch
    io_in_key = 4'hE;
    tick(2);
    io_in_key = 4'hF;
    tick(8);
    rd(5'd10, 32'h0, "glitch_lvl");
    rd(5'd11, 32'h0, "glitch_evt");

    // 4. masked key1 press
    wr(5'd13, 32'h02);
    io_in_key = 4'hD;
    tick(10);
    check("key1_irq", {31'b0, irq}, 32'h1);
    rd(5'd10, 32'h2, "key1_lvl");
    rd(5'd11, 32'h2, "key1_evt");
    check("key1_irq_clear", {31'b0, irq}, 32'h0);
    rd(5'd11, 32'h0, "key1_evt_cleared");
    io_in_key = 4'hF;
    tick(8);

    // 5. read lands on the same edge as key2's debounced press
    wr(5'd13, 32'h04);
    io_in_key = 4'hB;
    tick(5);
    rd(5'd11, 32'h0, "key2_race_old");
    check("key2_irq", {31'b0, irq}, 32'h1);
    rd(5'd11, 32'h4, "key2_evt");
    check("key2_irq_clear", {31'b0, irq}, 32'h0);
    io_in_key = 4'hF;
    tick(8);

    // 6. build up nonzero state, then reset mid-debounce
    wr(5'd13, 32'h10);
    io_in_sw = 10'h000;
    tick(8);
    wr(5'd12, 32'h005);
    check("sw_w1c_irq", {31'b0, irq}, 32'h1);
    rd(5'd13, 32'h10, "cfg_rd");
    io_in_key = 4'h7;
    tick(3);
    resetn = 1'b0;
    #1;
    check("midrst_irq", {31'b0, irq}, 32'h0);
    check("midrst_data_out", data_out, 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    tick(5);
    rd(5'd11, 32'h0, "key3_not_yet");
    rd(5'd11, 32'h8, "key3_evt");
    check("key3_irq_unmasked", {31'b0, irq}, 32'h0);
    rd(5'd12, 32'h0, "sw_chg_after_rst");

    tick(2);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_reads: got %0d, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
